// File: rtl/crack_scheduler.sv
// crack_scheduler: owns the RC4 key space and hands one candidate key at a
// time to each cracking core. It issues keys in ascending order, stops on the
// first success and drains the cores still working before reporting DONE.
// All outputs come straight from registers.
module crack_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 22,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_found,
  output logic                           busy,
  output logic                           found,
  output logic                           exhausted,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [IDX_W-1:0]               found_core
);

  localparam int KW1 = KEY_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Registered state
  state_t                         state_r;
  logic [KW1-1:0]                 next_key_r;   // MSB set once every key has been issued
  logic [NUM_CORES-1:0]           active_r;     // core holds a key it has not reported on
  logic [NUM_CORES-1:0]           core_start_r;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_r;
  logic                           busy_r;
  logic                           found_r;
  logic                           exhausted_r;
  logic [KEY_WIDTH-1:0]           found_key_r;
  logic [IDX_W-1:0]               found_core_r;

  // Next-state values
  state_t                         state_s;
  logic [KW1-1:0]                 next_key_s;
  logic [NUM_CORES-1:0]           active_s;
  logic [NUM_CORES-1:0]           core_start_s;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_s;
  logic                           busy_s;
  logic                           found_s;
  logic                           exhausted_s;
  logic [KEY_WIDTH-1:0]           found_key_s;
  logic [IDX_W-1:0]               found_core_s;

  // Per-cycle helpers
  logic [NUM_CORES-1:0]           retire_s;
  logic [NUM_CORES-1:0]           active_left_s;
  logic [NUM_CORES-1:0]           hit_s;
  logic [NUM_CORES-1:0]           idle_s;
  logic [NUM_CORES-1:0]           disp_oh_s;
  logic [IDX_W-1:0]               hit_idx_s;
  logic [IDX_W-1:0]               idle_idx_s;

  // Lowest set bit index; the loop runs downward so the lowest index wins.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  // Next-state, retirement, result capture and single-key dispatch.
  always_comb begin
    state_s      = state_r;
    next_key_s   = next_key_r;
    active_s     = active_r;
    core_start_s = {NUM_CORES{1'b0}};
    core_key_s   = core_key_r;
    found_s      = found_r;
    exhausted_s  = exhausted_r;
    found_key_s  = found_key_r;
    found_core_s = found_core_r;
    disp_oh_s    = {NUM_CORES{1'b0}};

    // core_done on a core that holds no key is ignored
    retire_s      = core_done & active_r;
    active_left_s = active_r & ~retire_s;
    hit_s         = retire_s & core_found;
    // a core retiring this cycle is not yet idle, so it is never re-dispatched in the same edge
    idle_s        = ~active_r;
    hit_idx_s     = lowest_set(hit_s);
    idle_idx_s    = lowest_set(idle_s);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // key 0 goes straight to core 0 so it is visible in the first busy cycle
          state_s                   = ST_RUN;
          found_s                   = 1'b0;
          exhausted_s               = 1'b0;
          active_s                  = NUM_CORES'(1);
          core_start_s              = NUM_CORES'(1);
          core_key_s[KEY_WIDTH-1:0] = {KEY_WIDTH{1'b0}};
          next_key_s                = KW1'(1);
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (|hit_s) begin
          found_s      = 1'b1;
          found_core_s = hit_idx_s;
          found_key_s  = core_key_r[hit_idx_s*KEY_WIDTH +: KEY_WIDTH];
          active_s     = active_left_s;
          state_s      = (|active_left_s) ? ST_DRAIN : ST_DONE;
        end else if (!next_key_r[KEY_WIDTH] && (|idle_s)) begin
          disp_oh_s[idle_idx_s]                           = 1'b1;
          core_start_s                                    = disp_oh_s;
          core_key_s[idle_idx_s*KEY_WIDTH +: KEY_WIDTH]   = next_key_r[KEY_WIDTH-1:0];
          active_s                                        = active_left_s | disp_oh_s;
          next_key_s                                      = next_key_r + KW1'(1);
        end else if (next_key_r[KEY_WIDTH] && !(|active_left_s)) begin
          active_s    = active_left_s;
          exhausted_s = 1'b1;
          state_s     = ST_DONE;
        end else begin
          active_s = active_left_s;
        end
      end
      ST_DRAIN: begin
        active_s = active_left_s;
        if (!(|active_left_s)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_RUN) || (state_s == ST_DRAIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      next_key_r   <= {KW1{1'b0}};
      active_r     <= {NUM_CORES{1'b0}};
      core_start_r <= {NUM_CORES{1'b0}};
      core_key_r   <= {(NUM_CORES*KEY_WIDTH){1'b0}};
      busy_r       <= 1'b0;
      found_r      <= 1'b0;
      exhausted_r  <= 1'b0;
      found_key_r  <= {KEY_WIDTH{1'b0}};
      found_core_r <= {IDX_W{1'b0}};
    end else begin
      state_r      <= state_s;
      next_key_r   <= next_key_s;
      active_r     <= active_s;
      core_start_r <= core_start_s;
      core_key_r   <= core_key_s;
      busy_r       <= busy_s;
      found_r      <= found_s;
      exhausted_r  <= exhausted_s;
      found_key_r  <= found_key_s;
      found_core_r <= found_core_s;
    end
  end

  assign core_start = core_start_r;
  assign core_key   = core_key_r;
  assign busy       = busy_r;
  assign found      = found_r;
  assign exhausted  = exhausted_r;
  assign found_key  = found_key_r;
  assign found_core = found_core_r;

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler: a 4-core / 22-bit instance for dispatch,
// reset, find, restart and simultaneous-find behaviour, and a 4-core / 4-bit
// instance that sweeps the whole key space.
module tb_crack_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  core_start;
  logic [87:0] core_key;
  logic [3:0]  core_done;
  logic [3:0]  core_found;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [21:0] found_key;
  logic [1:0]  found_core;

  logic        start4;
  logic [3:0]  core_start4;
  logic [15:0] core_key4;
  logic [3:0]  core_done4;
  logic [3:0]  core_found4;
  logic        busy4;
  logic        found4;
  logic        exhausted4;
  logic [3:0]  found_key4;
  logic [1:0]  found_core4;

  // Core model state and manual overrides
  logic        model_en;
  logic [3:0]  model_done;
  logic [3:0]  model_found;
  logic [3:0]  man_done;
  logic [3:0]  man_found;
  logic [3:0]  pend;
  int          cnt [4];
  logic [21:0] mkey [4];
  logic [3:0]  model4_done;
  logic [3:0]  pend4;
  int          cnt4 [4];

  int          starts_total = 0;
  int          starts4      = 0;
  int          seen4 [16]   = '{default: 0};
  int          tests_run    = 0;
  int          tests_failed = 0;

  assign core_done   = model_done | man_done;
  assign core_found  = model_found | man_found;
  assign core_done4  = model4_done;
  assign core_found4 = 4'b0000;

  crack_scheduler dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .core_start(core_start),
    .core_key  (core_key),
    .core_done (core_done),
    .core_found(core_found),
    .busy      (busy),
    .found     (found),
    .exhausted (exhausted),
    .found_key (found_key),
    .found_core(found_core)
  );

  crack_scheduler #(.NUM_CORES(4), .KEY_WIDTH(4)) dut4 (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start4),
    .core_start(core_start4),
    .core_key  (core_key4),
    .core_done (core_done4),
    .core_found(core_found4),
    .busy      (busy4),
    .found     (found4),
    .exhausted (exhausted4),
    .found_key (found_key4),
    .found_core(found_core4)
  );

  // 50 MHz clock
  always #10 CLOCK_50 = ~CLOCK_50;

  // Core model for the 22-bit instance: answers 5 cycles after core_start, found only for key 0x2A
  always @(negedge CLOCK_50) begin
    model_done  = 4'b0000;
    model_found = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (!reset || !model_en) begin
        pend[c] = 1'b0;
        cnt[c]  = 0;
      end else begin
        if (pend[c]) begin
          if (cnt[c] == 1) begin
            model_done[c]  = 1'b1;
            model_found[c] = (mkey[c] == 22'h00002A);
            pend[c]        = 1'b0;
          end else begin
            cnt[c] = cnt[c] - 1;
          end
        end
        if (core_start[c]) begin
          pend[c] = 1'b1;
          cnt[c]  = 5;
          mkey[c] = core_key[c*22 +: 22];
        end
      end
    end
  end

  // Core model for the 4-bit instance: answers 2 cycles after core_start, never found
  always @(negedge CLOCK_50) begin
    model4_done = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (!reset) begin
        pend4[c] = 1'b0;
        cnt4[c]  = 0;
      end else begin
        if (pend4[c]) begin
          if (cnt4[c] == 1) begin
            model4_done[c] = 1'b1;
            pend4[c]       = 1'b0;
          end else begin
            cnt4[c] = cnt4[c] - 1;
          end
        end
        if (core_start4[c]) begin
          pend4[c] = 1'b1;
          cnt4[c]  = 2;
        end
      end
    end
  end

  // Dispatch logger
  always @(negedge CLOCK_50) begin
    starts_total += $countones(core_start);
    starts4      += $countones(core_start4);
    for (int c = 0; c < 4; c++) begin
      if (core_start4[c] === 1'b1) seen4[core_key4[c*4 +: 4]]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int base;
    int i;
    reset     = 1'b0;
    start     = 1'b0;
    start4    = 1'b0;
    model_en  = 1'b0;
    man_done  = 4'b0000;
    man_found = 4'b0000;

    // Reset state
    repeat (3) tick;
    check_eq("rst_core_start", core_start, 4'b0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_found", found, 1'b0);
    check_eq("rst_exhausted", exhausted, 1'b0);
    reset = 1'b1;
    tick;

    // Dispatch order with cores that never finish
    start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("disp_busy", busy, 1'b1);
    check_eq("disp_start0", core_start, 4'b0001);
    check_eq("disp_key0", core_key[21:0], 22'd0);
    tick;
    check_eq("disp_start1", core_start, 4'b0010);
    check_eq("disp_key1", core_key[43:22], 22'd1);
    tick;
    check_eq("disp_start2", core_start, 4'b0100);
    check_eq("disp_key2", core_key[65:44], 22'd2);
    tick;
    check_eq("disp_start3", core_start, 4'b1000);
    check_eq("disp_key3", core_key[87:66], 22'd3);
    tick;
    check_eq("disp_idle_a", core_start, 4'b0000);
    tick;
    check_eq("disp_idle_b", core_start, 4'b0000);

    // Reset held for 3 cycles mid-search
    reset = 1'b0;
    repeat (3) tick;
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_key", core_key[31:0], 32'd0);
    check_eq("mrst_found_key", found_key, 22'd0);
    check_eq("mrst_found_core", found_core, 2'd0);
    reset = 1'b1;
    base  = starts_total;
    repeat (5) tick;
    check_eq("mrst_no_starts", starts_total - base, 32'd0);
    check_eq("mrst_busy_after", busy, 1'b0);

    // Find key 0x2A: key k goes to core k%4, so core 2 holds it; 45 keys issued
    model_en = 1'b1;
    base     = starts_total;
    start    = 1'b1;
    tick;
    start = 1'b0;
    i = 0;
    while (!found && i < 300) begin
      tick;
      i++;
    end
    check_eq("find_in_time", found, 1'b1);
    check_eq("find_key", found_key, 22'h00002A);
    check_eq("find_core", found_core, 2'd2);
    check_eq("find_exh", exhausted, 1'b0);
    check_eq("find_draining", busy, 1'b1);
    i = 0;
    while (busy && i < 50) begin
      tick;
      i++;
    end
    check_eq("find_drained", busy, 1'b0);
    check_eq("find_keys_issued", starts_total - base, 32'd45);
    check_eq("find_hold", found, 1'b1);

    // Restart from DONE, start held in RUN, spurious done on idle core 3
    model_en = 1'b0;
    start    = 1'b1;
    tick;
    check_eq("rs_found_clr", found, 1'b0);
    check_eq("rs_start0", core_start, 4'b0001);
    check_eq("rs_key0", core_key[21:0], 22'd0);
    man_done  = 4'b1000;
    man_found = 4'b1000;
    tick;
    man_done  = 4'b0000;
    man_found = 4'b0000;
    check_eq("rs_spurious_found", found, 1'b0);
    check_eq("rs_start1", core_start, 4'b0010);
    check_eq("rs_key1", core_key[43:22], 22'd1);
    tick;
    check_eq("rs_start2", core_start, 4'b0100);
    tick;
    check_eq("rs_start3", core_start, 4'b1000);
    check_eq("rs_key3", core_key[87:66], 22'd3);
    start = 1'b0;
    tick;
    check_eq("rs_no_repeat", core_start, 4'b0000);

    // Simultaneous find on cores 1 and 3: core 1 (key 1) wins
    man_done  = 4'b1010;
    man_found = 4'b1010;
    tick;
    man_done  = 4'b0000;
    man_found = 4'b0000;
    check_eq("sim_found", found, 1'b1);
    check_eq("sim_core", found_core, 2'd1);
    check_eq("sim_key", found_key, 22'd1);
    check_eq("sim_drain", busy, 1'b1);
    man_done  = 4'b0010;
    man_found = 4'b0010;
    tick;
    man_done  = 4'b0000;
    man_found = 4'b0000;
    check_eq("sim_spur_core", found_core, 2'd1);
    check_eq("sim_spur_busy", busy, 1'b1);
    man_done = 4'b0101;
    tick;
    man_done = 4'b0000;
    check_eq("sim_done_busy", busy, 1'b0);
    check_eq("sim_done_found", found, 1'b1);
    check_eq("sim_done_key", found_key, 22'd1);

    // Exhaustion of the 4-bit key space
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    i = 0;
    while (busy4 && i < 300) begin
      tick;
      i++;
    end
    check_eq("exh_done", busy4, 1'b0);
    check_eq("exh_flag", exhausted4, 1'b1);
    check_eq("exh_found", found4, 1'b0);
    check_eq("exh_count", starts4, 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("exh_key%0d_once", k), seen4[k], 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
